asfifo_wr_arb: RTL and testbench
================================

Name: asfifo_wr_arb

Overview:
Round-robin write-port arbiter that shares the write side of one asfifo instance among NREQ requesters in the BIU write-clock domain.
- Grants one requester at a time for a burst.
- Bursts end on the requester's last flag or at MAX_BURST beats.
- Tags each FIFO word with the source ID so the read side can demultiplex.
- Throttles all traffic against the FIFO's full flag.

Parameters:
NREQ, 4, number of requesters (1..16)
WIDTH, 16, requester data width
MAX_BURST, 8, max beats per grant (>=1)
IDLE_TO, 16, cycles a granted requester may hold req_valid low before the grant is revoked; 0 disables the timeout
IDW (localparam), clog2(NREQ) with minimum 1, source ID width

Ports:
clk  in  1  single clock, the FIFO write clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester data valid
req_last  in  NREQ  per-requester last beat of burst
req_data  in  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  out  NREQ  per-requester accept; a beat transfers when valid and ready are both high
port_en  in  NREQ  per-requester enable mask; disabled ports are never granted
fifo_wr_en  out  1  to asfifo wr_en
fifo_wr_data  out  WIDTH+IDW  {grant_id, data} to asfifo wr_data
fifo_wr_full  in  1  from asfifo wr_full
grant_vld  out  1  a burst grant is active
grant_id  out  IDW  index of the granted requester

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, grant_vld=0, grant_id=0, beat_cnt=0, idle_cnt=0. req_ready=0, fifo_wr_en=0, fifo_wr_data=0 while in reset.
- FSM has two states: IDLE and BURST.
- IDLE arbitration:
  - Candidates are req_valid & port_en.
  - The winner is the first candidate found scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - On the next edge: state=BURST, grant_vld=1, grant_id=winner, beat_cnt=0, idle_cnt=0.
  - No transfer occurs in an IDLE cycle, so arbitration latency is 1 cycle. req_ready is all zero in IDLE.
- BURST, with g=grant_id:
  - req_ready[g] = ~fifo_wr_full. All other req_ready bits are 0.
  - xfer = req_valid[g] & ~fifo_wr_full & port_en[g].
  - fifo_wr_en = xfer (combinational).
  - fifo_wr_data = {g, req_data[g]} while grant_vld=1, otherwise 0.
- Burst end condition: xfer & (req_last[g] | beat_cnt==MAX_BURST-1).
  - On end: state=IDLE, grant_vld=0, rr_ptr=(g+1) mod NREQ.
  - Otherwise on xfer: beat_cnt++ and idle_cnt=0.
- Stall cases in BURST:
  - fifo_wr_full=1 holds the grant indefinitely; no beat is counted and idle_cnt does not advance.
  - req_valid[g]=0 with full=0 increments idle_cnt. When IDLE_TO!=0 and idle_cnt reaches IDLE_TO-1, the FSM revokes the grant: state=IDLE, rr_ptr=g+1.
- Abort: port_en[g]=0 in BURST forces req_ready[g]=0 and no transfer. The FSM returns to IDLE on the next edge with rr_ptr=g+1.
- Back-to-back grants: at least one IDLE cycle separates bursts. A requester that just finished loses priority to every other pending enabled requester.
- NREQ=1: rr_ptr stays 0; IDW=1 and the ID bit is always 0.
- Full is sampled combinationally each cycle. A beat is never presented to the FIFO while fifo_wr_full=1, so there is no overflow.
- beat_cnt is clog2(MAX_BURST)+1 bits wide and never wraps, because the burst ends at MAX_BURST-1.
- Reset mid-burst aborts immediately. Partially written bursts are not recalled; the read side discards them by ID/last protocol.

Test Plan:
1. Reset then req 0 alone, 3 beats data 0x0001..0x0003 with last on beat 3 -> grant_vld rises 1 cycle after req_valid. fifo_wr_en high 3 cycles with fifo_wr_data=0x00001..0x00003 (ID 0). Returns to IDLE and rr_ptr=1.
2. All 4 requesters valid continuously, no last, MAX_BURST=8 -> grants in order 0,1,2,3,0. Each grant carries exactly 8 beats. One IDLE cycle between grants.
3. fifo_wr_full asserted for 5 cycles mid-burst on beat 4 of req 2 -> req_ready[2]=0 and fifo_wr_en=0 for those 5 cycles. beat_cnt holds at 4. Burst resumes and ends after 8 total beats with no beat lost or duplicated.
4. port_en=4'b1010 with all req_valid=1 -> only IDs 1 and 3 are granted, alternating. port_en[3] cleared mid-burst -> next cycle req_ready[3]=0; IDLE follows, then grant to 1.
5. IDLE_TO=16: req 1 granted, then req_valid[1] drops -> grant revoked after 16 cycles with req_valid[1] low. Pending req 2 is granted on the following cycle.
6. rst asserted asynchronously during a burst -> all outputs read 0 in the same timestep. After release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/asfifo_wr_arb.sv
// Round-robin arbiter sharing one asfifo write port among NREQ requesters.
// A grant lasts until the requester's last beat or MAX_BURST beats. It is also
// released when the port is disabled or the requester idles too long. Every
// FIFO word carries the source ID so the read side can demultiplex.
module asfifo_wr_arb #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned IDLE_TO   = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NREQ-1:0]                              req_valid,
    input  logic [NREQ-1:0]                              req_last,
    input  logic [NREQ*WIDTH-1:0]                        req_data,
    output logic [NREQ-1:0]                              req_ready,
    input  logic [NREQ-1:0]                              port_en,
    output logic                                         fifo_wr_en,
    output logic [WIDTH+((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] fifo_wr_data,
    input  logic                                         fifo_wr_full,
    output logic                                         grant_vld,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]   grant_id
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BCW = $clog2(MAX_BURST) + 1;
    localparam int unsigned ICW = $clog2(IDLE_TO + 1) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   grant_id_d;
    logic             grant_vld_d;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [ICW-1:0]   idle_cnt_q, idle_cnt_d;

    logic [NREQ-1:0]  cand;
    logic             win_vld;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   scan_idx;

    logic             sel_valid;
    logic             sel_last;
    logic             sel_en;
    logic [WIDTH-1:0] sel_data;
    logic             xfer;
    logic             burst_end;
    logic [IDW-1:0]   next_ptr;

    // Round-robin scan of enabled, valid requesters starting at rr_ptr
    always_comb begin
        cand     = req_valid & port_en;
        win_vld  = 1'b0;
        win_id   = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_idx = IDW'((32'(rr_ptr_q) + 32'(i)) % NREQ);
            if (!win_vld && cand[scan_idx]) begin
                win_vld = 1'b1;
                win_id  = scan_idx;
            end
        end
    end

    // Granted requester's signals and the beat-transfer qualifier
    always_comb begin
        sel_valid = req_valid[grant_id];
        sel_last  = req_last[grant_id];
        sel_en    = port_en[grant_id];
        sel_data  = req_data[32'(grant_id)*WIDTH +: WIDTH];
        xfer      = (state_q == BURST) && sel_valid && !fifo_wr_full && sel_en;
        burst_end = xfer && (sel_last || (beat_cnt_q == BCW'(MAX_BURST - 1)));
        if (32'(grant_id) == NREQ - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_id + IDW'(1);
        end
    end

    // Next-state logic: arbitration in IDLE, beat/idle accounting in BURST
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id;
        grant_vld_d = grant_vld;
        beat_cnt_d  = beat_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d     = BURST;
                    grant_vld_d = 1'b1;
                    grant_id_d  = win_id;
                    beat_cnt_d  = '0;
                    idle_cnt_d  = '0;
                end
            end
            BURST: begin
                if (!sel_en) begin
                    // port disabled mid-burst: abandon the grant
                    state_d     = IDLE;
                    grant_vld_d = 1'b0;
                    rr_ptr_d    = next_ptr;
                end else if (fifo_wr_full) begin
                    // back-pressure holds the grant with counters frozen
                    state_d = BURST;
                end else if (sel_valid) begin
                    if (burst_end) begin
                        state_d     = IDLE;
                        grant_vld_d = 1'b0;
                        rr_ptr_d    = next_ptr;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                        idle_cnt_d = '0;
                    end
                end else if (IDLE_TO != 0) begin
                    if (idle_cnt_q == ICW'(IDLE_TO - 1)) begin
                        state_d     = IDLE;
                        grant_vld_d = 1'b0;
                        rr_ptr_d    = next_ptr;
                    end else begin
                        idle_cnt_d = idle_cnt_q + ICW'(1);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                grant_vld_d = 1'b0;
            end
        endcase
    end

    // FIFO-facing outputs follow the live grant and full flag
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (!rst) begin
            if (state_q == BURST) begin
                req_ready[grant_id] = !fifo_wr_full && sel_en;
            end
            fifo_wr_en = xfer;
            if (grant_vld) begin
                fifo_wr_data = {grant_id, sel_data};
            end
        end
    end

    // State and grant registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_vld  <= 1'b0;
            grant_id   <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_vld  <= grant_vld_d;
            grant_id   <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_asfifo_wr_arb.sv
// Directed bench for asfifo_wr_arb with default parameters.
module tb_asfifo_wr_arb;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned IDW   = 2;

    logic                    clk;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_last;
    logic [NREQ*WIDTH-1:0]   req_data;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         port_en;
    logic                    fifo_wr_en;
    logic [WIDTH+IDW-1:0]    fifo_wr_data;
    logic                    fifo_wr_full;
    logic                    grant_vld;
    logic [IDW-1:0]          grant_id;

    int checks = 0;
    int errors = 0;

    asfifo_wr_arb #(
        .NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(8), .IDLE_TO(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .port_en(port_en),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_wr_full(fifo_wr_full),
        .grant_vld(grant_vld), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_data();
        for (int i = 0; i < int'(NREQ); i++) begin
            req_data[i*WIDTH +: WIDTH] = WIDTH'(32'hA000 + i);
        end
    endtask

    // One IDLE gap then n transfer beats from requester id (constant data)
    task automatic run_burst(input int id, input int n);
        logic [WIDTH+IDW-1:0] exp_w;
        exp_w = {IDW'(id), WIDTH'(32'hA000 + id)};
        @(negedge clk);
        chk("gap_grant_vld", 32'(grant_vld), 32'd0);
        chk("gap_wr_en", 32'(fifo_wr_en), 32'd0);
        next_cycle();
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            chk("burst_grant_vld", 32'(grant_vld), 32'd1);
            chk("burst_grant_id", 32'(grant_id), 32'(id));
            chk("burst_wr_en", 32'(fifo_wr_en), 32'd1);
            chk("burst_wr_data", 32'(fifo_wr_data), 32'(exp_w));
            next_cycle();
        end
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_last     = '0;
        req_data     = '0;
        port_en      = '1;
        fifo_wr_full = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_grant_vld", 32'(grant_vld), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        next_cycle();
        rst = 1'b0;

        // 1: single requester, 3-beat burst ending on last
        req_valid = 4'b0001;
        req_data[0 +: WIDTH] = 16'h0001;
        @(negedge clk);
        chk("t1_idle_vld", 32'(grant_vld), 32'd0);
        chk("t1_idle_ready", 32'(req_ready), 32'd0);
        chk("t1_idle_wr_en", 32'(fifo_wr_en), 32'd0);
        next_cycle();
        for (int b = 1; b <= 3; b++) begin
            req_data[0 +: WIDTH] = WIDTH'(b);
            req_last = (b == 3) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            chk("t1_grant_vld", 32'(grant_vld), 32'd1);
            chk("t1_grant_id", 32'(grant_id), 32'd0);
            chk("t1_ready", 32'(req_ready), 32'h1);
            chk("t1_wr_en", 32'(fifo_wr_en), 32'd1);
            chk("t1_wr_data", 32'(fifo_wr_data), 32'(b));
            next_cycle();
        end
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        chk("t1_end_vld", 32'(grant_vld), 32'd0);
        chk("t1_end_wr_en", 32'(fifo_wr_en), 32'd0);
        next_cycle();
        // rr_ptr=1: with 0 and 1 both pending, 1 must win
        req_valid = 4'b0011;
        req_last  = 4'b0010;
        set_all_data();
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("t1_rrptr_id", 32'(grant_id), 32'd1);
        next_cycle();
        req_valid = '0;
        req_last  = '0;

        // 2: restart from rr_ptr=0, all requesters streaming, full bursts
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        req_valid = 4'b1111;
        run_burst(0, 8);
        run_burst(1, 8);
        run_burst(2, 8);
        run_burst(3, 8);
        run_burst(0, 8);

        // 3: full stall of 5 cycles after 4 beats of requester 2
        req_valid = 4'b0100;
        req_data[2*WIDTH +: WIDTH] = 16'h0001;
        @(negedge clk);
        chk("t3_idle_vld", 32'(grant_vld), 32'd0);
        next_cycle();
        for (int b = 1; b <= 4; b++) begin
            req_data[2*WIDTH +: WIDTH] = WIDTH'(b);
            @(negedge clk);
            chk("t3_pre_wr_en", 32'(fifo_wr_en), 32'd1);
            chk("t3_pre_data", 32'(fifo_wr_data), 32'h20000 + 32'(b));
            chk("t3_pre_ready", 32'(req_ready), 32'h4);
            next_cycle();
        end
        fifo_wr_full = 1'b1;
        req_data[2*WIDTH +: WIDTH] = 16'h0005;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("t3_full_ready", 32'(req_ready), 32'h0);
            chk("t3_full_wr_en", 32'(fifo_wr_en), 32'd0);
            chk("t3_full_vld", 32'(grant_vld), 32'd1);
            next_cycle();
        end
        fifo_wr_full = 1'b0;
        for (int b = 5; b <= 8; b++) begin
            req_data[2*WIDTH +: WIDTH] = WIDTH'(b);
            @(negedge clk);
            chk("t3_post_wr_en", 32'(fifo_wr_en), 32'd1);
            chk("t3_post_data", 32'(fifo_wr_data), 32'h20000 + 32'(b));
            chk("t3_post_vld", 32'(grant_vld), 32'd1);
            next_cycle();
        end

        // 4: only ports 1 and 3 enabled, then port 3 disabled mid-burst
        port_en   = 4'b1010;
        req_valid = 4'b1111;
        set_all_data();
        run_burst(3, 8);
        run_burst(1, 8);
        run_burst(3, 2);
        port_en = 4'b0010;
        @(negedge clk);
        chk("t4_abort_ready", 32'(req_ready), 32'h0);
        chk("t4_abort_wr_en", 32'(fifo_wr_en), 32'd0);
        next_cycle();
        req_last = 4'b0010;
        @(negedge clk);
        chk("t4_after_vld", 32'(grant_vld), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t4_regrant_vld", 32'(grant_vld), 32'd1);
        chk("t4_regrant_id", 32'(grant_id), 32'd1);
        chk("t4_regrant_wr_en", 32'(fifo_wr_en), 32'd1);
        next_cycle();
        req_valid = '0;
        req_last  = '0;
        port_en   = 4'b1111;

        // 5: idle timeout revokes requester 1, pending requester 2 follows
        req_valid = 4'b0010;
        @(negedge clk);
        chk("t5_idle_vld", 32'(grant_vld), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t5_first_id", 32'(grant_id), 32'd1);
        chk("t5_first_wr_en", 32'(fifo_wr_en), 32'd1);
        next_cycle();
        req_valid = 4'b0100;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            chk("t5_hold_vld", 32'(grant_vld), 32'd1);
            chk("t5_hold_id", 32'(grant_id), 32'd1);
            chk("t5_hold_wr_en", 32'(fifo_wr_en), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("t5_revoked_vld", 32'(grant_vld), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t5_next_vld", 32'(grant_vld), 32'd1);
        chk("t5_next_id", 32'(grant_id), 32'd2);
        next_cycle();

        // 6: asynchronous reset mid-burst, then arbitration from rr_ptr=0
        #2;
        rst = 1'b1;
        #1;
        chk("t6_vld", 32'(grant_vld), 32'd0);
        chk("t6_id", 32'(grant_id), 32'd0);
        chk("t6_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("t6_wr_data", 32'(fifo_wr_data), 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd0);
        next_cycle();
        rst = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("t6_idle_vld", 32'(grant_vld), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t6_regrant_vld", 32'(grant_vld), 32'd1);
        chk("t6_regrant_id", 32'(grant_id), 32'd0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
